t10_lcd_frame_controller: RTL and testbench
===========================================

Name: t10_lcd_frame_controller

Overview:
- Parametrised HD44780-class character LCD driver for ROWS x COLS displays (1-4 rows, 8-20 columns) in 8-bit write-only mode.
- After power-up delay and init it does not refresh continuously. A frame is sent on a strobe, from a snapshot of the text buffer latched when the frame starts. An optional continuous mode refreshes back-to-back.
- Sits between the team's text/UI logic (which builds row_data) and the LCD pins. It exposes ready/busy so upstream logic knows when a frame has landed.

Parameters:
- CLK_DIV, 20_000, clk cycles per LCD transfer slot; must be >= 4.
- POWERUP_SLOTS, 10, slots of idle delay after reset before init.
- ROWS, 2, display rows, 1..4.
- COLS, 16, characters per row, 8..20.
- CONTINUOUS, 0, 0: a frame only on strobe; 1: a new frame starts automatically after each frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- row_data  in  ROWS*COLS*8  text buffer; row r, column c is at bits [(ROWS*COLS-1-(r*COLS+c))*8 +: 8] (row 0 col 0 in MSBs)
- strobe  in  1  one-cycle frame request
- ready  out  1  init sequence complete
- busy  out  1  frame in progress
- lcd_en  out  1  LCD enable
- lcd_rw  out  1  constant 0
- lcd_rs  out  1  0 = command, 1 = character
- lcd_data  out  8  LCD data bus

Behaviour:
- Reset (async, any time including mid-frame):
  - lcd_en=0, lcd_rs=0, lcd_data=0x00, busy=0, ready=0.
  - pending flag cleared; FSM to PWRUP; all counters 0.
- Slot timing:
  - slot_cnt counts 0..CLK_DIV-1 only in INIT and FRAME states; it is held at 0 otherwise.
  - lcd_en=1 when slot_cnt <= (CLK_DIV-1)/2, else 0; lcd_en=0 in PWRUP and IDLE.
  - lcd_data and lcd_rs are registered, change only on the first cycle of a slot, and are stable for the whole slot.
- PWRUP:
  - Lasts POWERUP_SLOTS*CLK_DIV cycles after reset deassertion; outputs keep reset values.
  - Then go to INIT.
- INIT: 5 slots, rs=0, in order 0x38, 0x08, 0x01, 0x06, 0x0C.
- IDLE:
  - ready=1 is asserted on the first IDLE cycle and stays 1 until reset.
  - Strobes during PWRUP/INIT are ignored.
- Frame start (strobe=1 in IDLE, or CONTINUOUS=1 on IDLE entry, or pending=1 on IDLE entry):
  - Next cycle: row_data is latched into a shadow register, busy=1, first slot begins.
- FRAME, for r = 0..ROWS-1:
  - One address slot: rs=0, data = 0x80 | base(r). base = 0x00, 0x40, COLS, 0x40+COLS for r = 0..3.
  - Then COLS character slots: rs=1, data = shadow byte (r,c), c ascending.
  - Frame length = ROWS*(COLS+1) slots.
- Frame end:
  - After the last slot's final cycle, go to IDLE; busy=0 in that cycle.
  - lcd_data/lcd_rs hold their last values.
- Strobe while busy:
  - Sets pending (multiple strobes collapse into one); the shadow is not modified mid-frame.
  - On IDLE entry with pending=1, pending is cleared and a new frame starts next cycle with a fresh latch. busy drops for exactly one cycle.
- Strobe on the same cycle as frame end counts as pending.
- No dropped or duplicated bytes; row_data changes mid-frame never appear in the current frame.

Test Plan:
1. CLK_DIV=4, POWERUP_SLOTS=2, ROWS=2, COLS=4; release reset -> lcd_en=0 for 8 cycles; then 5 slots with rs=0, data 0x38, 0x08, 0x01, 0x06, 0x0C; each slot has lcd_en high 2 cycles, low 2 cycles; ready=1 at cycle 28.
2. After ready, row_data=0x41424344_45464748 and one strobe pulse -> busy=1 for 40 cycles; bytes in order: 0x80(rs0), 0x41..0x44(rs1), 0xC0(rs0), 0x45..0x48(rs1); busy=0; no further lcd_en pulses.
3. Change row_data to all 0x5A during slot 3 of a frame -> current frame still sends the original bytes; the next strobed frame sends 0x5A.
4. Two strobes during a busy frame -> exactly one extra frame follows; busy low for exactly 1 cycle between frames.
5. ROWS=4, COLS=20 -> address bytes 0x80, 0xC0, 0x94, 0xD4; frame = 84 slots.
6. Assert rst mid-frame (async, between clock edges) -> all outputs return to reset values immediately; after release the PWRUP and INIT sequence repeats and ready=0 until INIT completes.

Source files
------------

// File: rtl/t10_lcd_frame_controller_if.sv
// ---------------------------------------------------------------------------
// t10_lcd_frame_controller_if
//   Bundle between the text/UI logic, the LCD frame controller and the LCD
//   pins.
//   row_data  text buffer; row r, column c is at
//             bits [(ROWS*COLS-1-(r*COLS+c))*8 +: 8], so row 0 col 0 is in
//             the MSBs
//   strobe    one-cycle frame request
//   ready     init sequence complete
//   busy      frame in progress
//   lcd_en / lcd_rw / lcd_rs / lcd_data   HD44780 8-bit write-only pins
//   Modports: master = upstream text logic, slave = the frame controller.
// ---------------------------------------------------------------------------
interface t10_lcd_frame_controller_if #(
  parameter int ROWS = 2,
  parameter int COLS = 16
);
  logic [ROWS*COLS*8-1:0] row_data;
  logic                   strobe;
  logic                   ready;
  logic                   busy;
  logic                   lcd_en;
  logic                   lcd_rw;
  logic                   lcd_rs;
  logic [7:0]             lcd_data;

  modport master (
    output row_data, strobe,
    input  ready, busy, lcd_en, lcd_rw, lcd_rs, lcd_data
  );

  modport slave (
    input  row_data, strobe,
    output ready, busy, lcd_en, lcd_rw, lcd_rs, lcd_data
  );
endinterface

// File: rtl/t10_lcd_frame_controller.sv
// ---------------------------------------------------------------------------
// t10_lcd_frame_controller
//   HD44780-class character LCD driver, 8-bit write-only mode, for
//   ROWS x COLS displays (1..4 rows, 8..20 columns).
//   After a power-up delay and a fixed init sequence it sends one frame per
//   strobe (or back-to-back when CONTINUOUS=1) from a snapshot of row_data
//   taken when the frame starts. Strobes arriving during a frame collapse
//   into a single follow-up frame.
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   slave side of t10_lcd_frame_controller_if (row_data, strobe,
//           ready, busy, lcd_en, lcd_rw, lcd_rs, lcd_data)
//   Every LCD transfer occupies one slot of CLK_DIV clocks: lcd_en is high
//   for the first half of the slot, lcd_rs/lcd_data change only on the
//   first cycle of a slot.
// ---------------------------------------------------------------------------
module t10_lcd_frame_controller #(
  parameter int CLK_DIV       = 20_000,
  parameter int POWERUP_SLOTS = 10,
  parameter int ROWS          = 2,
  parameter int COLS          = 16,
  parameter int CONTINUOUS    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  t10_lcd_frame_controller_if.slave     bus
);

  localparam int NBYTES     = ROWS * COLS;
  localparam int SLOT_W     = $clog2(CLK_DIV);
  localparam int PWR_CYCLES = POWERUP_SLOTS * CLK_DIV;
  localparam int PWR_W      = (PWR_CYCLES > 1) ? $clog2(PWR_CYCLES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] EN_LAST   = SLOT_W'((CLK_DIV - 1) / 2);
  localparam logic [PWR_W-1:0]  PWR_LAST  = PWR_W'((PWR_CYCLES > 0) ? PWR_CYCLES - 1 : 0);
  localparam logic [4:0]        COL_LAST  = 5'(COLS);
  localparam logic [1:0]        ROW_LAST  = 2'(ROWS - 1);
  localparam logic [4:0]        INIT_LAST = 5'd4;

  typedef enum logic [1:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_FRAME
  } state_t;

  state_t                 state, state_nx;
  logic [SLOT_W-1:0]      slot_cnt, slot_nx;
  logic [PWR_W-1:0]       pwr_cnt, pwr_nx;
  // In INIT col_idx is the init-command index; in FRAME 0 is the address
  // slot and 1..COLS are the character slots of row row_idx.
  logic [4:0]             col_idx, col_nx;
  logic [1:0]             row_idx, row_nx;
  logic                   start;
  logic                   pending;
  logic [NBYTES*8-1:0]    shadow;

  logic                   ready_q, busy_q, en_q, rs_q;
  logic [7:0]             data_q;

  logic                   byte_rs;
  logic [7:0]             byte_data;
  int                     char_pos;

  function automatic logic [7:0] init_byte(input logic [4:0] idx);
    case (idx)
      5'd0:    return 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      5'd1:    return 8'h08;  // display off
      5'd2:    return 8'h01;  // clear
      5'd3:    return 8'h06;  // entry mode: increment, no shift
      default: return 8'h0C;  // display on, cursor off
    endcase
  endfunction

  // DDRAM start address of each row on HD44780-class panels.
  function automatic logic [7:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'(COLS);
      default: return 8'(64 + COLS);
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of an always_comb so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    slot_nx  = slot_cnt;
    pwr_nx   = pwr_cnt;
    col_nx   = col_idx;
    row_nx   = row_idx;
    start    = 1'b0;

    case (state)
      S_PWRUP: begin
        if (pwr_cnt == PWR_LAST) begin
          state_nx = S_INIT;
          pwr_nx   = '0;
        end else begin
          pwr_nx = pwr_cnt + 1'b1;
        end
      end

      S_INIT: begin
        if (slot_cnt == SLOT_LAST) begin
          slot_nx = '0;
          if (col_idx == INIT_LAST) begin
            state_nx = S_IDLE;
            col_nx   = '0;
          end else begin
            col_nx = col_idx + 1'b1;
          end
        end else begin
          slot_nx = slot_cnt + 1'b1;
        end
      end

      S_IDLE: begin
        // pending is only ever set during FRAME, so it is seen here on the
        // first IDLE cycle after the frame that collected the strobe.
        if (bus.strobe || pending || (CONTINUOUS != 0)) begin
          start    = 1'b1;
          state_nx = S_FRAME;
        end
      end

      S_FRAME: begin
        if (slot_cnt == SLOT_LAST) begin
          slot_nx = '0;
          if (col_idx == COL_LAST) begin
            col_nx = '0;
            if (row_idx == ROW_LAST) begin
              state_nx = S_IDLE;
              row_nx   = '0;
            end else begin
              row_nx = row_idx + 1'b1;
            end
          end else begin
            col_nx = col_idx + 1'b1;
          end
        end else begin
          slot_nx = slot_cnt + 1'b1;
        end
      end

      default: state_nx = S_PWRUP;
    endcase
  end

  // Byte for the slot that begins after the next edge. Character slots read
  // the shadow, which was loaded one slot earlier at frame start.
  always_comb begin
    byte_rs   = 1'b0;
    byte_data = 8'h00;
    char_pos  = NBYTES - int'(row_nx) * COLS - int'(col_nx);
    if (state_nx == S_INIT) begin
      byte_data = init_byte(col_nx);
    end else if (col_nx == 5'd0) begin
      byte_data = 8'h80 | row_base(row_nx);
    end else begin
      byte_rs   = 1'b1;
      byte_data = shadow[char_pos*8 +: 8];
    end
  end

  // ---------------------------------------------------------------------
  // State, counters and registered LCD pins
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_PWRUP;
      slot_cnt <= '0;
      pwr_cnt  <= '0;
      col_idx  <= '0;
      row_idx  <= '0;
      pending  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state    <= state_nx;
      slot_cnt <= slot_nx;
      pwr_cnt  <= pwr_nx;
      col_idx  <= col_nx;
      row_idx  <= row_nx;

      // A strobe on the last FRAME cycle is still caught here.
      if (state == S_FRAME && bus.strobe) begin
        pending <= 1'b1;
      end else if (start) begin
        pending <= 1'b0;
      end

      ready_q <= ready_q | (state_nx == S_IDLE);
      busy_q  <= (state_nx == S_FRAME);
      en_q    <= ((state_nx == S_INIT) || (state_nx == S_FRAME)) && (slot_nx <= EN_LAST);

      // Load only on a slot's first cycle; after the last slot the pins
      // keep their final values.
      if (((state_nx == S_INIT) || (state_nx == S_FRAME)) && (slot_nx == '0)) begin
        rs_q   <= byte_rs;
        data_q <= byte_data;
      end
    end
  end

  // NOTE: the shadow is a plain data store that is always written at frame
  // start before any character slot reads it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      shadow <= bus.row_data;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.lcd_en   = en_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_data = data_q;

endmodule

// File: tb/tb_t10_lcd_frame_controller.sv
// ---------------------------------------------------------------------------
// tb_t10_lcd_frame_controller
//   Directed bench: dut_a is a 2x4 panel, dut_b a 4x20 panel, both with
//   CLK_DIV=4 and POWERUP_SLOTS=2. A negedge monitor per DUT records
//   {rs,data} at each rising lcd_en.
// ---------------------------------------------------------------------------
module tb_t10_lcd_frame_controller;

  localparam int D = 4;
  localparam int P = 2;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  t10_lcd_frame_controller_if #(.ROWS(2), .COLS(4))  ifa ();
  t10_lcd_frame_controller_if #(.ROWS(4), .COLS(20)) ifb ();

  t10_lcd_frame_controller #(
    .CLK_DIV(D), .POWERUP_SLOTS(P), .ROWS(2), .COLS(4), .CONTINUOUS(0)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa.slave)
  );

  t10_lcd_frame_controller #(
    .CLK_DIV(D), .POWERUP_SLOTS(P), .ROWS(4), .COLS(20), .CONTINUOUS(0)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb.slave)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte monitors.
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic       pen_a = 1'b0;
  logic       pen_b = 1'b0;

  always @(negedge clk) begin
    if (ifa.lcd_en && !pen_a) qa.push_back({ifa.lcd_rs, ifa.lcd_data});
    if (ifb.lcd_en && !pen_b) qb.push_back({ifb.lcd_rs, ifb.lcd_data});
    pen_a <= ifa.lcd_en;
    pen_b <= ifb.lcd_en;
  end

  logic [7:0] init_tab [5] = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

  logic [8:0] exp2[$] = '{9'h080, 9'h141, 9'h142, 9'h143, 9'h144,
                          9'h0C0, 9'h145, 9'h146, 9'h147, 9'h148};
  logic [8:0] exp3[$] = '{9'h080, 9'h15A, 9'h15A, 9'h15A, 9'h15A,
                          9'h0C0, 9'h15A, 9'h15A, 9'h15A, 9'h15A};
  logic [8:0] exp4[$];
  logic [7:0] addr_b [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};

  task automatic strobe_a();
    ifa.strobe = 1'b1;
    @(negedge clk);
    ifa.strobe = 1'b0;
  endtask

  task automatic strobe_b();
    ifb.strobe = 1'b1;
    @(negedge clk);
    ifb.strobe = 1'b0;
  endtask

  task automatic count_busy(input bit sel, output int len);
    len = 0;
    while ((sel ? ifb.busy : ifa.busy) && len < 1000) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic count_idle(input bit sel, input int limit, output int len);
    len = 0;
    while (!(sel ? ifb.busy : ifa.busy) && len < limit) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_qa(input int n);
    int t = 0;
    while (qa.size() < n && t < 1000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("wait_qa", 32'(qa.size() >= n), 32'd1);
  endtask

  task automatic cmp_bytes(input string tag, input logic [8:0] got[$], input logic [8:0] exp[$]);
    check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      check(tag, 32'((i < got.size()) ? got[i] : 9'h1FF), 32'(exp[i]));
    end
  endtask

  // Releases rst_a and checks the power-up gap, the five init slots and the
  // ready edge at cycle 28. Strobes are pulsed during PWRUP and INIT and
  // must have no effect.
  task automatic init_seq_a();
    int ph;
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 0; k <= 28; k++) begin
      ifa.strobe = (k == 3 || k == 12);
      ph = (k - 8) % 4;
      check("init_en", 32'(ifa.lcd_en), 32'(k >= 8 && k < 28 && ph < 2));
      check("init_ready", 32'(ifa.ready), 32'(k == 28));
      check("init_busy", 32'(ifa.busy), 32'd0);
      if (k < 8) check("pwrup_data", 32'(ifa.lcd_data), 32'h00);
      if (k >= 8 && k < 28 && (ph == 0 || ph == 3)) begin
        check("init_data", 32'(ifa.lcd_data), 32'(init_tab[(k - 8) / 4]));
        check("init_rs", 32'(ifa.lcd_rs), 32'd0);
      end
      if (k < 28) @(negedge clk);
    end
    ifa.strobe = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len;
    int rest;
    int low;

    rst_a        = 1'b1;
    rst_b        = 1'b1;
    ifa.strobe   = 1'b0;
    ifb.strobe   = 1'b0;
    ifa.row_data = 64'h41424344_45464748;
    for (int i = 0; i < 80; i++) ifb.row_data[(79 - i)*8 +: 8] = 8'(i + 1);

    #1;
    check("rst_en", 32'(ifa.lcd_en), 32'd0);
    check("rst_rs", 32'(ifa.lcd_rs), 32'd0);
    check("rst_rw", 32'(ifa.lcd_rw), 32'd0);

    repeat (2) @(negedge clk);
    rst_b = 1'b0;

    // 1: power-up delay and init sequence
    init_seq_a();
    count_idle(0, 10, low);
    check("no_frame_after_init", 32'(low), 32'd10);
    check("no_bytes_after_init", 32'(qa.size()), 32'd5);

    // 2: single strobed frame
    qa.delete();
    strobe_a();
    check("busy_start2", 32'(ifa.busy), 32'd1);
    count_busy(0, len);
    check("busy_len2", 32'(len), 32'd40);
    cmp_bytes("frame2", qa, exp2);
    check("hold_data2", 32'(ifa.lcd_data), 32'h48);
    check("hold_rs2", 32'(ifa.lcd_rs), 32'd1);
    repeat (20) @(negedge clk);
    check("no_extra2", 32'(qa.size()), 32'd10);
    check("busy_after2", 32'(ifa.busy), 32'd0);

    // 3: row_data changes mid-frame are not seen until the next frame
    qa.delete();
    strobe_a();
    wait_qa(3);
    ifa.row_data = {8{8'h5A}};
    count_busy(0, len);
    cmp_bytes("frame3a", qa, exp2);
    @(negedge clk);
    qa.delete();
    strobe_a();
    count_busy(0, len);
    cmp_bytes("frame3b", qa, exp3);

    // 4: two strobes during a frame give exactly one extra frame
    ifa.row_data = 64'h41424344_45464748;
    @(negedge clk);
    qa.delete();
    strobe_a();
    check("busy_start4", 32'(ifa.busy), 32'd1);
    repeat (6) @(negedge clk);
    strobe_a();
    repeat (10) @(negedge clk);
    strobe_a();
    count_busy(0, rest);
    check("busy_len4a", 32'(18 + rest), 32'd40);
    count_idle(0, 50, low);
    check("gap4", 32'(low), 32'd1);
    count_busy(0, len);
    check("busy_len4b", 32'(len), 32'd40);
    count_idle(0, 60, low);
    check("no_third4", 32'(low), 32'd60);
    exp4 = {exp2, exp2};
    cmp_bytes("frame4", qa, exp4);

    // 4b: strobe on the last busy cycle becomes pending
    strobe_a();
    repeat (39) @(negedge clk);
    check("last_busy4b", 32'(ifa.busy), 32'd1);
    strobe_a();
    check("gap4b", 32'(ifa.busy), 32'd0);
    @(negedge clk);
    count_busy(0, len);
    check("busy_len4b2", 32'(len), 32'd40);
    count_idle(0, 30, low);
    check("no_third4b", 32'(low), 32'd30);

    // 5: 4x20 panel addresses and frame length
    check("ready_b", 32'(ifb.ready), 32'd1);
    qb.delete();
    strobe_b();
    count_busy(1, len);
    check("busy_len5", 32'(len), 32'd336);
    check("frame5_count", 32'(qb.size()), 32'd84);
    for (int r = 0; r < 4; r++) begin
      check("addr5", 32'((r*21 < qb.size()) ? qb[r*21] : 9'h1FF), 32'({1'b0, addr_b[r]}));
      for (int c = 0; c < 20; c++) begin
        check("char5", 32'((r*21 + 1 + c < qb.size()) ? qb[r*21 + 1 + c] : 9'h1FF),
              32'({1'b1, 8'(r*20 + c + 1)}));
      end
    end

    // 6: asynchronous reset mid-frame, then a full restart
    @(negedge clk);
    qa.delete();
    strobe_a();
    wait_qa(3);
    check("en_before_rst", 32'(ifa.lcd_en), 32'd1);
    #1;
    rst_a = 1'b1;
    #1;
    check("rst6_en", 32'(ifa.lcd_en), 32'd0);
    check("rst6_busy", 32'(ifa.busy), 32'd0);
    check("rst6_ready", 32'(ifa.ready), 32'd0);
    check("rst6_rs", 32'(ifa.lcd_rs), 32'd0);
    check("rst6_data", 32'(ifa.lcd_data), 32'h00);
    strobe_a();
    @(negedge clk);
    init_seq_a();
    count_idle(0, 10, low);
    check("no_frame_after_rst", 32'(low), 32'd10);
    qa.delete();
    strobe_a();
    count_busy(0, len);
    check("busy_len6", 32'(len), 32'd40);
    cmp_bytes("frame6", qa, exp2);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
